fir_filter_seq: RTL and testbench
=================================

Name: fir_filter_seq

Overview:
- Parametrised, time-multiplexed FIR filter: one shared multiply-accumulate (MAC) unit, circular sample delay line, register-based coefficient memory loadable at run time.
- Generalises the fixed 71-tap filter. Adds:
  - parametrised widths and tap count;
  - valid/ready sample handshake and an output valid strobe;
  - output saturation with a saturation flag.
- Sits between the sample source and downstream decimation/output logic.

Parameters:
- DATA_W, 4: signed sample width.
- COEFF_W, 8: signed coefficient width.
- NUM_TAPS, 71: number of taps; must be >= 2.
- ADDR_W, 7: coefficient address width; must satisfy 2^ADDR_W >= NUM_TAPS.
- ACC_W, 19: signed accumulator width; must be >= DATA_W+COEFF_W+clog2(NUM_TAPS).
- OUT_W, 12: signed output width; must be <= ACC_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  DATA_W  signed input sample.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  block can accept a sample or a coefficient write this cycle.
- coeff_write  in  1  coefficient write strobe.
- coeff_addr  in  ADDR_W  tap index to write.
- coeff_in  in  COEFF_W  signed coefficient value.
- fir_out  out  OUT_W  signed filter output; held between strobes.
- fir_valid  out  1  one-cycle strobe: fir_out updated.
- sat_flag  out  1  the result presented with fir_valid was clamped.

Behaviour:
- **Reset** (rst high at a rising edge):
  - state=IDLE; delay line, all coefficients, write pointer and accumulator cleared to 0;
  - fir_out=0, fir_valid=0, sat_flag=0;
  - sample_ready=1 from the first cycle after reset.
- **Reset mid-operation:** aborts any computation with no fir_valid; rst has priority over all other inputs.
- **FSM states:** IDLE, MAC, DONE.
- **IDLE** (sample_ready=1):
  - sample_valid=1 at an edge accepts the sample:
    - written into the delay line as x[n] at the write pointer;
    - pointer advances, wrapping NUM_TAPS-1 -> 0;
    - tap counter k=0, acc=0, state -> MAC.
  - coeff_write=1 at an edge in IDLE writes coeff[coeff_addr]=coeff_in.
  - coeff_addr >= NUM_TAPS: write ignored.
  - Simultaneous sample_valid and coeff_write in IDLE: both take effect; the new coefficient is used by the computation just started.
- **MAC** (sample_ready=0):
  - each edge: acc += coeff[k] * x[n-k] (full-precision signed product, sign-extended to ACC_W); k increments.
  - x[n-k] is taken from the circular delay line; x[n] is the newest sample.
  - after the edge with k=NUM_TAPS-1, state -> DONE.
  - sample_valid and coeff_write are ignored (not buffered).
- **DONE** (sample_ready=0): next edge registers fir_out=sat(acc), sets fir_valid=1 and sat_flag, state -> IDLE.
- **Saturation:**
  - acc > 2^(OUT_W-1)-1 -> fir_out = 2^(OUT_W-1)-1, sat_flag=1;
  - acc < -2^(OUT_W-1) -> fir_out = -2^(OUT_W-1), sat_flag=1;
  - otherwise fir_out = acc, sat_flag=0.
  - No scaling or rounding.
- **Strobe timing:**
  - fir_valid and sat_flag are high for exactly one cycle;
  - sat_flag is 0 whenever fir_valid=0;
  - fir_out holds its value until the next strobe.
- **Latency:** fir_valid asserts NUM_TAPS+1 edges after the accepting edge, in the same cycle sample_ready returns high.
- **Throughput:** one sample per NUM_TAPS+2 cycles (73 at defaults).
- **Start-up:** delay-line history before the first accepted sample after reset is zero.

Test Plan:
- Reset/idle: assert rst for 3 cycles mid-MAC -> no fir_valid; then fir_out=0, sat_flag=0, sample_ready=1; a subsequent sample of 0 yields fir_out=0.
- Coefficient load and impulse: write coeff[i]=i for i=0..70 (plus addr 100 = 55, which must be ignored); feed 1 then 70 samples of 0 via the handshake -> 71 fir_valid strobes with fir_out = 0,1,2,...,70; the 72nd zero sample gives 0; sat_flag=0 throughout; each strobe 72 edges after acceptance.
- Positive step with saturation: same coefficients, feed 1 continuously -> fir_out = m(m+1)/2 for m=0..63 (last unclamped 2016, sat_flag=0); from m=64 onward fir_out=2047 with sat_flag=1.
- Negative impulse/step: feed -1 (4'hF) impulse -> 0,-1,...,-70; then continuous -1 -> -2016 at m=63, then -2048 with sat_flag=1.
- Handshake/ignore rules: hold sample_valid high continuously -> exactly one sample accepted per 73 cycles; coeff_write pulsed during MAC -> coefficient unchanged (verify via a later impulse); simultaneous sample_valid+coeff_write in IDLE -> new coefficient used for that sample.

Source files
------------

// File: rtl/fir_filter_seq.sv
// Time-multiplexed FIR filter: one shared MAC walks all taps per accepted sample,
// circular sample delay line, run-time writable coefficient registers, saturated output.
module fir_filter_seq #(
    parameter int DATA_W   = 4,
    parameter int COEFF_W  = 8,
    parameter int NUM_TAPS = 71,
    parameter int ADDR_W   = 7,
    parameter int ACC_W    = 19,
    parameter int OUT_W    = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DATA_W-1:0]  sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic                      coeff_write,
    input  logic [ADDR_W-1:0]         coeff_addr,
    input  logic signed [COEFF_W-1:0] coeff_in,
    output logic signed [OUT_W-1:0]   fir_out,
    output logic                      fir_valid,
    output logic                      sat_flag
);
    localparam int PTR_W  = $clog2(NUM_TAPS);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_TAPS - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t state_q, state_d;

    logic signed [DATA_W-1:0]  dline [NUM_TAPS];
    logic signed [COEFF_W-1:0] coeff [NUM_TAPS];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr, k;
    logic signed [ACC_W-1:0]   acc;
    logic signed [PROD_W-1:0]  prod;
    logic signed [OUT_W-1:0]   sat_val;
    logic                      sat_hit;
    logic                      accept, coeff_we;

    assign sample_ready = (state_q == IDLE);
    assign accept       = sample_ready && sample_valid;
    assign coeff_we     = sample_ready && coeff_write && (32'(coeff_addr) < 32'(NUM_TAPS));
    // rd_ptr walks backwards from the newest sample, so tap k sees x[n-k]
    assign prod         = dline[rd_ptr] * coeff[k];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (k == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sat_val = acc[OUT_W-1:0];
        sat_hit = 1'b0;
        if (acc > OUT_MAX) begin
            sat_val = OUT_MAX[OUT_W-1:0];
            sat_hit = 1'b1;
        end else if (acc < OUT_MIN) begin
            sat_val = OUT_MIN[OUT_W-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            k         <= '0;
            acc       <= '0;
            fir_out   <= '0;
            fir_valid <= 1'b0;
            sat_flag  <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                dline[i] <= '0;
                coeff[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            fir_valid <= 1'b0;
            sat_flag  <= 1'b0;
            // coefficient write lands on the same edge as a sample accept, so the
            // MAC pass that starts next already sees it
            if (coeff_we) coeff[PTR_W'(coeff_addr)] <= coeff_in;
            case (state_q)
                IDLE: if (accept) begin
                    dline[wr_ptr] <= sample_in;
                    rd_ptr        <= wr_ptr;
                    wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
                    k             <= '0;
                    acc           <= '0;
                end
                MAC: begin
                    acc    <= acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
                    k      <= k + PTR_W'(1);
                    rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - PTR_W'(1);
                end
                DONE: begin
                    fir_out   <= sat_val;
                    fir_valid <= 1'b1;
                    sat_flag  <= sat_hit;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_filter_seq.sv
// Bench for fir_filter_seq: per-cycle comparison against a sum-of-products model of
// the filter, plus directed impulse/step/handshake vectors with literal expectations.
module tb_fir_filter_seq;
    localparam int NT = 71;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [3:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic              coeff_write = 1'b0;
    logic [6:0]        coeff_addr = '0;
    logic signed [7:0] coeff_in = '0;
    logic signed [11:0] fir_out;
    logic              fir_valid, sat_flag;

    fir_filter_seq dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .coeff_write(coeff_write), .coeff_addr(coeff_addr),
        .coeff_in(coeff_in), .fir_out(fir_out), .fir_valid(fir_valid), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int val; int sat; int due; } exp_t;
    exp_t pend[$];
    int   mcoef [NT];
    int   hist  [NT];
    int   held;
    bit   inited = 1'b0;

    always @(negedge clk) begin
        bit   exp_ready, due_now;
        int   y, s;
        exp_t e;
        cyc++;
        exp_ready = 1'b1;
        if (inited) begin
            due_now   = (pend.size() > 0) && (pend[0].due == cyc);
            exp_ready = (pend.size() == 0) || due_now;
            chk("ready", int'(sample_ready), int'(exp_ready));
            chk("valid", int'(fir_valid), int'(due_now));
            if (due_now) begin
                e    = pend.pop_front();
                held = e.val;
                chk("sat", int'(sat_flag), e.sat);
            end else
                chk("sat_idle", int'(sat_flag), 0);
            chk("fir_out", int'(fir_out), held);
        end
        if (rst) begin
            pend.delete();
            held   = 0;
            inited = 1'b1;
            for (int i = 0; i < NT; i++) begin mcoef[i] = 0; hist[i] = 0; end
        end else if (inited) begin
            if (coeff_write && exp_ready && int'(coeff_addr) < NT) mcoef[coeff_addr] = int'(coeff_in);
            if (sample_valid && exp_ready) begin
                for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'(sample_in);
                y = 0;
                for (int i = 0; i < NT; i++) y += mcoef[i] * hist[i];
                s = 0;
                if (y > 2047) begin y = 2047; s = 1; end
                else if (y < -2048) begin y = -2048; s = 1; end
                e.val = y; e.sat = s; e.due = cyc + 73;
                pend.push_back(e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wcoef(input int a, input int v);
        @(posedge clk); #1;
        coeff_write = 1'b1; coeff_addr = a[6:0]; coeff_in = v[7:0];
        @(posedge clk); #1;
        coeff_write = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < NT; i++) wcoef(i, i);
        wcoef(100, 55);
    endtask

    task automatic run_sample(input int s, input bit simul_cw, input bit mac_cw,
                              input int ca, input int cv, output int y, output int sf);
        int n;
        y = 0; sf = 0;
        @(posedge clk); #1;
        sample_valid = 1'b1; sample_in = s[3:0];
        if (simul_cw) begin coeff_write = 1'b1; coeff_addr = ca[6:0]; coeff_in = cv[7:0]; end
        n = 0;
        forever begin
            @(negedge clk);
            if (sample_ready) break;
            n++;
            if (n > 200) begin checks++; failures++; $display("FAIL accept_timeout cyc=%0d", cyc); break; end
        end
        @(posedge clk); #1;
        sample_valid = 1'b0; coeff_write = 1'b0;
        if (mac_cw) begin
            coeff_write = 1'b1; coeff_addr = ca[6:0]; coeff_in = cv[7:0];
            repeat (3) @(posedge clk);
            #1 coeff_write = 1'b0;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (fir_valid) begin y = int'(fir_out); sf = int'(sat_flag); break; end
            n++;
            if (n > 100) begin checks++; failures++; $display("FAIL strobe_timeout cyc=%0d", cyc); break; end
        end
    endtask

    initial begin
        int y, sf, cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out", int'(fir_out), 0);
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_valid", int'(fir_valid), 0);

        // impulse through ramp coefficients
        load_ramp();
        run_sample(1, 0, 0, 0, 0, y, sf);
        chk("imp0", y, 0);
        for (int m = 1; m <= 71; m++) begin
            run_sample(0, 0, 0, 0, 0, y, sf);
            if (m == 1)  chk("imp1", y, 1);
            if (m == 70) chk("imp70", y, 70);
            if (m == 71) chk("imp71", y, 0);
        end

        // positive step into saturation
        for (int m = 0; m <= 65; m++) begin
            run_sample(1, 0, 0, 0, 0, y, sf);
            if (m == 10) chk("step10", y, 55);
            if (m == 63) begin chk("step63", y, 2016); chk("step63_sat", sf, 0); end
            if (m == 64) begin chk("step64", y, 2047); chk("step64_sat", sf, 1); end
        end

        // reset in the middle of a MAC pass
        @(posedge clk); #1 sample_valid = 1'b1; sample_in = 4'sd3;
        @(posedge clk); #1 sample_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out", int'(fir_out), 0);
        chk("mid_rst_sat", int'(sat_flag), 0);
        chk("mid_rst_ready", int'(sample_ready), 1);
        run_sample(0, 0, 0, 0, 0, y, sf);
        chk("post_rst_zero", y, 0);

        // negative impulse and step (coefficients were cleared by reset)
        load_ramp();
        run_sample(-1, 0, 0, 0, 0, y, sf);
        for (int m = 1; m <= 71; m++) begin
            run_sample(0, 0, 0, 0, 0, y, sf);
            if (m == 70) chk("nimp70", y, -70);
        end
        for (int m = 0; m <= 65; m++) begin
            run_sample(-1, 0, 0, 0, 0, y, sf);
            if (m == 63) begin chk("nstep63", y, -2016); chk("nstep63_sat", sf, 0); end
            if (m == 64) begin chk("nstep64", y, -2048); chk("nstep64_sat", sf, 1); end
        end

        // valid held high: one accept per 73 cycles
        @(posedge clk); #1 sample_valid = 1'b1; sample_in = 4'sd0;
        cnt = 0;
        repeat (230) begin @(negedge clk); if (fir_valid) cnt++; end
        chk("hold_strobes", cnt, 3);
        @(posedge clk); #1 sample_valid = 1'b0;
        repeat (80) @(posedge clk);

        // coefficient write timing rules
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_sample(2, 1, 0, 0, 3, y, sf);
        chk("simul_cw", y, 6);
        run_sample(1, 0, 1, 0, -5, y, sf);
        chk("mac_cw_same", y, 3);
        run_sample(0, 0, 0, 0, 0, y, sf);
        chk("mac_cw_zero", y, 0);
        run_sample(1, 0, 0, 0, 0, y, sf);
        chk("mac_cw_kept", y, 3);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
